// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state type, default sizes and width helper for the FFT sample framer
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ARMED  = 2'd2,
        ST_RUN    = 2'd3
    } fft_state_e;

    localparam int FFT_LEN_DEF = 1024;
    localparam int DATA_W_DEF  = 8;

    function automatic int fft_clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fft_sync_fifo.sv
// rtl/fft_sync_fifo.sv - first-word-fall-through sync FIFO with flush; head reads as zero when empty
module fft_sync_fifo
    import fft_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = fft_clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_wr;
    logic             w_do_rd;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_rd   = i_rd_en && !o_empty;
    assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr && !i_flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

endmodule

// File: rtl/fft_sample_framer.sv
// rtl/fft_sample_framer.sv - lock-gated capture of one FFT frame of ADC samples onto a valid/ready stream
module fft_sample_framer
    import fft_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FFT_LEN     = FFT_LEN_DEF,
    parameter int FIFO_DEPTH  = 16,
    parameter int LOCK_SETTLE = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_lock,
    input  logic              start,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              ready_o,
    output logic              busy,
    output logic              ovf,
    output logic              lock_err
);

    localparam int CNT_W = fft_clog2(FFT_LEN);
    localparam int SET_W = fft_clog2(LOCK_SETTLE);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(FFT_LEN - 1);
    localparam logic [SET_W-1:0] SETTLE_END = SET_W'(LOCK_SETTLE - 1);

    fft_state_e       r_state;
    fft_state_e       w_next_state;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [SET_W-1:0] r_settle_cnt;
    logic             r_ready;
    logic             r_busy;
    logic             r_ovf;
    logic             r_lock_err;

    logic             w_push;
    logic             w_drop;
    logic             w_flush;
    logic             w_last;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [DATA_W:0]  w_head;

    fft_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (w_flush),
        .i_wr_en   (w_push),
        .i_wr_data ({adc_data, w_last}),
        .i_rd_en   (m_ready),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_pop    = !w_empty && m_ready;
    assign w_last   = (r_sample_cnt == LAST_IDX);
    assign m_valid  = !w_empty;
    assign m_data   = w_head[DATA_W:1];
    assign m_last   = w_head[0];
    assign ready_o  = r_ready;
    assign busy     = r_busy;
    assign ovf      = r_ovf;
    assign lock_err = r_lock_err;

    // A pop in the same cycle frees a slot, so a full FIFO only drops when the core is stalled.
    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (pll_lock) w_next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!pll_lock)                       w_next_state = ST_IDLE;
                else if (r_settle_cnt == SETTLE_END) w_next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (!pll_lock) begin
                    w_next_state = ST_IDLE;
                    w_flush      = 1'b1;
                end else if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!pll_lock) begin
                    w_next_state = ST_IDLE;
                    w_flush      = 1'b1;
                end else if (adc_valid) begin
                    if (!w_full || w_pop) begin
                        w_push = 1'b1;
                        if (w_last) w_next_state = ST_ARMED;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_ovf        <= 1'b0;
            r_lock_err   <= 1'b0;
            r_settle_cnt <= '0;
            r_sample_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_ready    <= (w_next_state == ST_ARMED);
            r_busy     <= (w_next_state == ST_RUN);
            if (w_drop)  r_ovf      <= 1'b1;
            if (w_flush) r_lock_err <= 1'b1;
            r_settle_cnt <= (r_state == ST_SETTLE && w_next_state == ST_SETTLE) ?
                            r_settle_cnt + 1'b1 : '0;
            if (r_state == ST_ARMED && w_next_state == ST_RUN) begin
                r_sample_cnt <= '0;
            end else if (w_push) begin
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end
        end
    end

endmodule
